// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main FSM of the multicycle MIPS datapath (JAL state built only with JAL_SUPPORT_EN)
module multicycle_control_unit #(
    parameter int STATE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode_i,
    input  logic                  mem_ready_i,
    output logic                  pc_write_o,
    output logic                  pc_write_cond_o,
    output logic                  branch_ne_o,
    output logic                  i_or_d_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  ir_write_o,
    output logic                  reg_write_o,
    output logic [1:0]            reg_dst_sel_o,
    output logic [1:0]            mem_to_reg_sel_o,
    output logic                  alu_src_a_o,
    output logic [1:0]            alu_src_b_sel_o,
    output logic [1:0]            alu_op_o,
    output logic [1:0]            pc_source_sel_o,
    output logic                  illegal_op_o,
    output logic [STATE_BITS-1:0] state_o
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef JAL_SUPPORT_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH     = STATE_BITS'(0),
        S_DECODE    = STATE_BITS'(1),
        S_MEM_ADDR  = STATE_BITS'(2),
        S_MEM_READ  = STATE_BITS'(3),
        S_MEM_WB    = STATE_BITS'(4),
        S_MEM_WRITE = STATE_BITS'(5),
        S_R_EXEC    = STATE_BITS'(6),
        S_R_WB      = STATE_BITS'(7),
        S_BRANCH    = STATE_BITS'(8),
        S_JUMP      = STATE_BITS'(9),
        S_ADDI_EXEC = STATE_BITS'(10),
`ifdef JAL_SUPPORT_EN
        S_ADDI_WB   = STATE_BITS'(11),
        S_JAL       = STATE_BITS'(12)
`else
        S_ADDI_WB   = STATE_BITS'(11)
`endif
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_dec;
    logic   w_legal;

    // state register, asynchronously forced to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // opcode dispatch target; FETCH doubles as the "unsupported opcode" marker
    always_comb begin
        w_dec = S_FETCH;
        case (opcode_i)
            OP_LW, OP_SW:   w_dec = S_MEM_ADDR;
            OP_R:           w_dec = S_R_EXEC;
            OP_ADDI:        w_dec = S_ADDI_EXEC;
            OP_BEQ, OP_BNE: w_dec = S_BRANCH;
            OP_J:           w_dec = S_JUMP;
`ifdef JAL_SUPPORT_EN
            OP_JAL:         w_dec = S_JAL;
`endif
            default:        w_dec = S_FETCH;
        endcase
    end

    assign w_legal = (w_dec != S_FETCH);

    // next-state sequencing, memory states hold until the handshake completes
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = w_dec;
            S_MEM_ADDR:  w_next = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // datapath controls decoded from the current state
    always_comb begin
        pc_write_o       = 1'b0;
        pc_write_cond_o  = 1'b0;
        branch_ne_o      = 1'b0;
        i_or_d_o         = 1'b0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        ir_write_o       = 1'b0;
        reg_write_o      = 1'b0;
        reg_dst_sel_o    = 2'b00;
        mem_to_reg_sel_o = 2'b00;
        alu_src_a_o      = 1'b0;
        alu_src_b_sel_o  = 2'b00;
        alu_op_o         = 2'b00;
        pc_source_sel_o  = 2'b00;
        illegal_op_o     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read_o      = 1'b1;
                alu_src_b_sel_o = 2'b01;
                ir_write_o      = mem_ready_i;
                pc_write_o      = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_sel_o = 2'b11;
                illegal_op_o    = !w_legal;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_sel_o = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o      = 1'b1;
                mem_to_reg_sel_o = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            S_R_WB: begin
                reg_write_o   = 1'b1;
                reg_dst_sel_o = 2'b01;
            end
            S_ADDI_WB: reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 2'b01;
                pc_write_cond_o = 1'b1;
                pc_source_sel_o = 2'b01;
                branch_ne_o     = (opcode_i == OP_BNE);
            end
            S_JUMP: begin
                pc_write_o      = 1'b1;
                pc_source_sel_o = 2'b10;
            end
`ifdef JAL_SUPPORT_EN
            S_JAL: begin
                pc_write_o       = 1'b1;
                pc_source_sel_o  = 2'b10;
                reg_write_o      = 1'b1;
                reg_dst_sel_o    = 2'b10;
                mem_to_reg_sel_o = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    assign state_o = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table, hand-sequence and random checks of the multicycle control FSM
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, m2r, src_b, alu_op, pc_src;
    logic       src_a, illegal;
    logic [3:0] state;
    logic [19:0] act;
    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit #(.STATE_BITS(4)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
        .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_write_o(reg_write), .reg_dst_sel_o(reg_dst), .mem_to_reg_sel_o(m2r),
        .alu_src_a_o(src_a), .alu_src_b_sel_o(src_b), .alu_op_o(alu_op),
        .pc_source_sel_o(pc_src), .illegal_op_o(illegal), .state_o(state)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, m2r, src_a, src_b, alu_op, pc_src, illegal};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, a, e);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
`ifdef JAL_SUPPORT_EN
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000011};
`else
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
`endif
    endfunction

    // expected control word for a state number, straight from the per-state output list
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
        logic pcw, pcwc, bne, iord, mr, mw, irw, rw, sa, ill;
        logic [1:0] rd, mtr, sb, aop, ps;
        {pcw, pcwc, bne, iord, mr, mw, irw, rw, sa, ill} = '0;
        {rd, mtr, sb, aop, ps} = '0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; ill = !legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; mtr = 2'b01; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; bne = (op == 6'b000101); end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            12: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mr, mw, irw, rw, rd, mtr, sa, sb, aop, ps, ill};
    endfunction

    // zero-wait state path of one instruction: {length, state nibbles first-to-last}
    function automatic logic [35:0] path_of(input logic [5:0] op);
        case (op)
            6'b000000: return {4'd4, 32'h0167};
            6'b100011: return {4'd5, 32'h01234};
            6'b101011: return {4'd4, 32'h0125};
            6'b000100, 6'b000101: return {4'd3, 32'h018};
            6'b001000: return {4'd4, 32'h01AB};
            6'b000010: return {4'd3, 32'h019};
`ifdef JAL_SUPPORT_EN
            6'b000011: return {4'd3, 32'h01C};
`endif
            default:   return {4'd2, 32'h01};
        endcase
    endfunction

    // per-cycle hand sequence: expected state trace plus mem_ready per cycle; entered at posedge+1
    task automatic run_seq(input string nm, input logic [5:0] op, input int n, input logic [31:0] tr, input logic [7:0] rdyb);
        for (int i = 0; i < n; i++) begin
            int st;
            st = int'(tr[4*(n-1-i) +: 4]);
            opcode = op;
            mem_ready = rdyb[i];
            @(negedge clk);
            chk({nm, ".state"}, 32'(state), 32'(st));
            chk({nm, ".ctrl"}, 32'(act), 32'(exp_out(st, op, rdyb[i])));
            @(posedge clk);
            #1;
        end
    endtask

    // random instruction with random memory waits, tracked against the zero-wait path
    task automatic run_rand(input logic [5:0] op);
        logic [35:0] p;
        int n;
        p = path_of(op);
        n = int'(p[35:32]);
        for (int i = 0; i < n; i++) begin
            int st;
            int w;
            logic rdy;
            st = int'(p[4*(n-1-i) +: 4]);
            w = 0;
            do begin
                rdy = (w < 6) ? ($urandom_range(0, 99) < 55) : 1'b1;
                opcode = op;
                mem_ready = rdy;
                @(negedge clk);
                chk("rand.state", 32'(state), 32'(st));
                chk("rand.ctrl", 32'(act), 32'(exp_out(st, op, rdy)));
                @(posedge clk);
                #1;
                w++;
            end while (!rdy && (st == 0 || st == 3 || st == 5));
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        int         n;
        logic [31:0] tr;
        logic [7:0] rdy;
    } vec_t;

    vec_t tv[12];
    logic [5:0] ops[8];

    initial begin
        tv[0]  = '{"r",       6'b000000, 4, 32'h0167,    8'hFF};
        tv[1]  = '{"lw",      6'b100011, 5, 32'h01234,   8'hFF};
        tv[2]  = '{"sw",      6'b101011, 4, 32'h0125,    8'hFF};
        tv[3]  = '{"beq",     6'b000100, 3, 32'h018,     8'hFF};
        tv[4]  = '{"bne",     6'b000101, 3, 32'h018,     8'hFF};
        tv[5]  = '{"addi",    6'b001000, 4, 32'h01AB,    8'hFF};
        tv[6]  = '{"j",       6'b000010, 3, 32'h019,     8'hFF};
`ifdef JAL_SUPPORT_EN
        tv[7]  = '{"jal",     6'b000011, 3, 32'h01C,     8'hFF};
`else
        tv[7]  = '{"jal_ill", 6'b000011, 2, 32'h01,      8'hFF};
`endif
        tv[8]  = '{"ill",     6'b111111, 2, 32'h01,      8'hFF};
        tv[9]  = '{"lw_wait", 6'b100011, 7, 32'h0123334, 8'hE7};
        tv[10] = '{"if_wait", 6'b000000, 5, 32'h00167,   8'h1E};
        tv[11] = '{"sw_wait", 6'b101011, 5, 32'h01255,   8'h17};
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000011};

        reset = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b0;
        #3;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.ctrl", 32'(act), 32'(exp_out(0, 6'b0, 1'b0)));
        mem_ready = 1'b1;
        #1;
        chk("rst.ctrl_rdy", 32'(act), 32'(exp_out(0, 6'b0, 1'b1)));
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[k]) run_seq(tv[k].name, tv[k].op, tv[k].n, tv[k].tr, tv[k].rdy);

        // asynchronous reset while MEM_WRITE waits on memory
        run_seq("sw_hold", 6'b101011, 4, 32'h0125, 8'h07);
        mem_ready = 1'b0;
        #1;
        chk("rstw.pre_state", 32'(state), 32'd5);
        reset = 1'b0;
        #1;
        chk("rstw.state", 32'(state), 32'd0);
        chk("rstw.mem_write", 32'(mem_write), 32'd0);
        chk("rstw.reg_write", 32'(reg_write), 32'd0);
        chk("rstw.mem_read", 32'(mem_read), 32'd1);
        chk("rstw.src_b", 32'(src_b), 32'd1);
        chk("rstw.pc_write", 32'(pc_write), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rstw.pc_write_rdy", 32'(pc_write), 32'd1);
        chk("rstw.ir_write_rdy", 32'(ir_write), 32'd1);
        mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_seq("post_rst", 6'b000010, 4, 32'h0019, 8'hFE);

        for (int k = 0; k < 300; k++)
            run_rand(($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
